// File: rtl/uart.sv
// Full-duplex 8N1 UART: 4 ticks per bit, CLOCK_DIVIDE clk cycles per tick.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx (+2 cycles latency).
module uart #(
   parameter int CLOCK_DIVIDE = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);

   localparam int DIV_W = $clog2(CLOCK_DIVIDE + 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLOCK_DIVIDE - 1);
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

   localparam logic [0:0] TX_IDLE    = 1'b0;
   localparam logic [0:0] TX_SENDING = 1'b1;

   localparam logic [2:0] RX_IDLE        = 3'd0;
   localparam logic [2:0] RX_CHECK_START = 3'd1;
   localparam logic [2:0] RX_READ_BITS   = 3'd2;
   localparam logic [2:0] RX_CHECK_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT_IDLE   = 3'd4;

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] rx_sync_q;

   always_ff @(posedge clk) begin
      if (rst) rx_sync_q <= 2'b11;
      else     rx_sync_q <= {rx_sync_q[0], rx};
   end

   assign rx_s = rx_sync_q[1];
`else
   assign rx_s = rx;
`endif

   // Transmitter: 9-bit shift register holds data plus stop bit behind the start bit.
   logic [0:0]       tx_state_q, tx_state_d;
   logic [DIV_W-1:0] tx_div_q, tx_div_d;
   logic [2:0]       tx_tick_q, tx_tick_d;
   logic [3:0]       tx_bits_q, tx_bits_d;
   logic [8:0]       tx_sr_q, tx_sr_d;
   logic             tx_q, tx_d;
   logic             tx_tick_end;

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_div_d    = tx_div_q;
      tx_tick_d   = tx_tick_q;
      tx_bits_d   = tx_bits_q;
      tx_sr_d     = tx_sr_q;
      tx_d        = tx_q;
      tx_tick_end = 1'b0;
      if (tx_state_q == TX_SENDING) begin
         if (tx_div_q == '0) begin
            tx_div_d    = DIV_RELOAD;
            tx_tick_d   = tx_tick_q - 3'd1;
            tx_tick_end = (tx_tick_q == 3'd1);
         end else begin
            tx_div_d = tx_div_q - DIV_ONE;
         end
      end
      case (tx_state_q)
         TX_IDLE: begin
            if (transmit) begin
               tx_sr_d    = {1'b1, tx_byte};
               tx_d       = 1'b0;
               tx_bits_d  = 4'd9;
               tx_div_d   = DIV_RELOAD;
               tx_tick_d  = 3'd4;
               tx_state_d = TX_SENDING;
            end
         end
         default: begin
            if (tx_tick_end) begin
               if (tx_bits_q == 4'd0) begin
                  tx_d       = 1'b1;
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_d      = tx_sr_q[0];
                  tx_sr_d   = {1'b1, tx_sr_q[8:1]};
                  tx_bits_d = tx_bits_q - 4'd1;
                  tx_tick_d = 3'd4;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_div_q   <= '0;
         tx_tick_q  <= 3'd0;
         tx_bits_q  <= 4'd0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_tick_q  <= tx_tick_d;
         tx_bits_q  <= tx_bits_d;
         tx_q       <= tx_d;
      end
   end

   always_ff @(posedge clk) tx_sr_q <= tx_sr_d;

   // Receiver: samples mid-bit; stop_ok marks the extra half-bit wait before completing.
   logic [2:0]       rx_state_q, rx_state_d;
   logic [DIV_W-1:0] rx_div_q, rx_div_d;
   logic [2:0]       rx_tick_q, rx_tick_d;
   logic [2:0]       rx_bits_q, rx_bits_d;
   logic [7:0]       rx_sr_q, rx_sr_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             stop_ok_q, stop_ok_d;
   logic             received_q, received_d;
   logic             recv_error_q, recv_error_d;
   logic             rx_tick_end;

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_div_d     = rx_div_q;
      rx_tick_d    = rx_tick_q;
      rx_bits_d    = rx_bits_q;
      rx_sr_d      = rx_sr_q;
      rx_byte_d    = rx_byte_q;
      stop_ok_d    = stop_ok_q;
      received_d   = 1'b0;
      recv_error_d = 1'b0;
      rx_tick_end  = 1'b0;
      if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_IDLE) begin
         if (rx_div_q == '0) begin
            rx_div_d    = DIV_RELOAD;
            rx_tick_d   = rx_tick_q - 3'd1;
            rx_tick_end = (rx_tick_q == 3'd1);
         end else begin
            rx_div_d = rx_div_q - DIV_ONE;
         end
      end
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_div_d   = DIV_RELOAD;
               rx_tick_d  = 3'd2;
               rx_state_d = RX_CHECK_START;
            end
         end
         RX_CHECK_START: begin
            if (rx_tick_end) begin
               if (!rx_s) begin
                  rx_tick_d  = 3'd4;
                  rx_bits_d  = 3'd0;
                  rx_state_d = RX_READ_BITS;
               end else begin
                  rx_state_d = RX_IDLE;
               end
            end
         end
         RX_READ_BITS: begin
            if (rx_tick_end) begin
               rx_sr_d   = {rx_s, rx_sr_q[7:1]};
               rx_tick_d = 3'd4;
               if (rx_bits_q == 3'd7) begin
                  stop_ok_d  = 1'b0;
                  rx_state_d = RX_CHECK_STOP;
               end else begin
                  rx_bits_d = rx_bits_q + 3'd1;
               end
            end
         end
         RX_CHECK_STOP: begin
            if (rx_tick_end) begin
               if (stop_ok_q) begin
                  rx_byte_d  = rx_sr_q;
                  received_d = 1'b1;
                  rx_state_d = RX_IDLE;
               end else if (rx_s) begin
                  stop_ok_d = 1'b1;
                  rx_tick_d = 3'd2;
               end else begin
                  recv_error_d = 1'b1;
                  rx_state_d   = RX_WAIT_IDLE;
               end
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q   <= RX_IDLE;
         rx_div_q     <= '0;
         rx_tick_q    <= 3'd0;
         rx_bits_q    <= 3'd0;
         rx_byte_q    <= 8'h00;
         stop_ok_q    <= 1'b0;
         received_q   <= 1'b0;
         recv_error_q <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_div_q     <= rx_div_d;
         rx_tick_q    <= rx_tick_d;
         rx_bits_q    <= rx_bits_d;
         rx_byte_q    <= rx_byte_d;
         stop_ok_q    <= stop_ok_d;
         received_q   <= received_d;
         recv_error_q <= recv_error_d;
      end
   end

   always_ff @(posedge clk) rx_sr_q <= rx_sr_d;

   assign tx              = tx_q;
   assign is_transmitting = (tx_state_q == TX_SENDING);
   assign is_receiving    = (rx_state_q != RX_IDLE);
   assign received        = received_q;
   assign recv_error      = recv_error_q;
   assign rx_byte         = rx_byte_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: random bytes against a frame-level serial model, plus loopback.
`timescale 1ns/1ps
module tb_uart;
   localparam int CD    = 8;
   localparam int BIT   = 4 * CD;
   localparam int FRAME = 40 * CD;

   logic clk = 1'b0, clk2 = 1'b0;
   logic rst, rx_drv, lb_sel, dut_rx;
   logic transmit, transmit2;
   logic [7:0] tx_byte, tx_byte2;
   logic tx, received, is_receiving, is_transmitting, recv_error;
   logic tx2, received2, is_receiving2, is_transmitting2, recv_error2;
   logic [7:0] rx_byte, rx_byte2;

   int checks = 0, errors = 0, cyc = 0;
   int rcv_cnt = 0, err_cnt = 0, both_cnt = 0, rcv_cyc = 0;
   int rcv2_cnt = 0, err2_cnt = 0, both2_cnt = 0;
   realtime rcv_time = 0.0, rcv2_time = 0.0;
   logic [7:0] rcv_val = 8'h00, rcv2_val = 8'h00;
   logic [7:0] rcv_q[$];
   logic [7:0] exp_rx_byte = 8'h00;

   always #5 clk = ~clk;
   always #4.99 clk2 = ~clk2;

   assign dut_rx = lb_sel ? tx2 : rx_drv;

   uart #(.CLOCK_DIVIDE(CD)) dut (
      .clk(clk), .rst(rst), .rx(dut_rx), .tx(tx), .transmit(transmit), .tx_byte(tx_byte),
      .received(received), .rx_byte(rx_byte), .is_receiving(is_receiving),
      .is_transmitting(is_transmitting), .recv_error(recv_error));

   uart #(.CLOCK_DIVIDE(CD)) dut2 (
      .clk(clk2), .rst(rst), .rx(tx), .tx(tx2), .transmit(transmit2), .tx_byte(tx_byte2),
      .received(received2), .rx_byte(rx_byte2), .is_receiving(is_receiving2),
      .is_transmitting(is_transmitting2), .recv_error(recv_error2));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (received) begin
         rcv_cnt  <= rcv_cnt + 1;
         rcv_cyc  <= cyc;
         rcv_time <= $realtime;
         rcv_val  <= rx_byte;
         rcv_q.push_back(rx_byte);
      end
      if (recv_error) err_cnt <= err_cnt + 1;
      if (received && recv_error) both_cnt <= both_cnt + 1;
   end

   always @(negedge clk2) begin
      if (received2) begin
         rcv2_cnt  <= rcv2_cnt + 1;
         rcv2_time <= $realtime;
         rcv2_val  <= rx_byte2;
      end
      if (recv_error2) err2_cnt <= err2_cnt + 1;
      if (received2 && recv_error2) both2_cnt <= both2_cnt + 1;
   end

   // Serial line image of one frame: index 0 is the start bit, index 9 the stop bit.
   function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic stop);
      return {stop, b, 1'b0};
   endfunction

   task automatic send_rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] fb;
      fb = frame_bits(b, stop);
      for (int i = 0; i < 10; i++) begin
         rx_drv = fb[i];
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (received !== 1'b0) begin errors++; $display("FAIL reset_received: got %b expected 0", received); end
      checks++; if (recv_error !== 1'b0) begin errors++; $display("FAIL reset_recv_error: got %b expected 0", recv_error); end
      checks++; if (is_receiving !== 1'b0) begin errors++; $display("FAIL reset_is_receiving: got %b expected 0", is_receiving); end
      checks++; if (is_transmitting !== 1'b0) begin errors++; $display("FAIL reset_is_transmitting: got %b expected 0", is_transmitting); end
      checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (tx !== 1'b1 || is_transmitting !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got tx=%b busy=%b expected tx=1 busy=0", tx, is_transmitting); end
   endtask

   task automatic test_tx(input logic [7:0] b, input logic [7:0] ignored);
      logic [9:0] fb;
      int high;
      fb = frame_bits(b, 1'b1);
      high = 0;
      @(negedge clk);
      tx_byte = b;
      transmit = 1'b1;
      for (int k = 0; k < 50 * CD; k++) begin
         @(negedge clk);
         if (k == 0) begin transmit = 1'b0; tx_byte = ~b; end
         if (k == 8 * CD) begin transmit = 1'b1; tx_byte = ignored; end
         if (k == 20 * CD) transmit = 1'b0;
         if (k < FRAME && (k % BIT) == BIT / 2) begin
            checks++;
            if (tx !== fb[k / BIT] || is_transmitting !== 1'b1) begin
               errors++;
               $display("FAIL tx_bit%0d byte %h: got tx=%b busy=%b expected tx=%b busy=1",
                        k / BIT, b, tx, is_transmitting, fb[k / BIT]);
            end
         end
         if (is_transmitting) high++;
         else break;
      end
      checks++; if (high != FRAME) begin errors++; $display("FAIL tx_busy_len: got %0d expected %0d", high, FRAME); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b expected 1", tx); end
      repeat (3) @(negedge clk);
      checks++; if (is_transmitting !== 1'b0) begin
         errors++; $display("FAIL tx_no_second_frame: got busy=%b expected 0", is_transmitting); end
   endtask

   task automatic test_rx(input logic [7:0] b);
      int r0, e0, start;
      r0 = rcv_cnt; e0 = err_cnt;
      @(negedge clk);
      start = cyc;
      send_rx_frame(b, 1'b1);
      repeat (8) @(negedge clk);
      checks++; if (rcv_cnt - r0 != 1) begin errors++; $display("FAIL rx_pulses: got %0d expected 1", rcv_cnt - r0); end
      checks++; if (rcv_val !== b || rx_byte !== b) begin
         errors++; $display("FAIL rx_byte: got pulse=%h reg=%h expected %h", rcv_val, rx_byte, b); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL rx_no_error: got %0d expected 0", err_cnt - e0); end
      checks++; if (rcv_cyc - start < FRAME + 1 || rcv_cyc - start > FRAME + 3) begin
         errors++; $display("FAIL rx_latency: got %0d expected %0d..%0d", rcv_cyc - start, FRAME + 1, FRAME + 3); end
      checks++; if (is_receiving !== 1'b0) begin errors++; $display("FAIL rx_idle_after: got %b expected 0", is_receiving); end
      exp_rx_byte = b;
   endtask

   task automatic test_rx_busy();
      logic [9:0] fb;
      logic [7:0] b;
      b = 8'($urandom);
      fb = frame_bits(b, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 10 * BIT; k++) begin
         rx_drv = fb[k / BIT];
         @(negedge clk);
         if (k == 5 * BIT) begin
            checks++;
            if (is_receiving !== 1'b1) begin errors++; $display("FAIL rx_busy_mid: got %b expected 1", is_receiving); end
         end
      end
      repeat (8) @(negedge clk);
      checks++; if (rx_byte !== b) begin errors++; $display("FAIL rx_busy_byte: got %h expected %h", rx_byte, b); end
      exp_rx_byte = b;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      int s0, e0;
      s0 = rcv_q.size(); e0 = err_cnt;
      for (int n = 0; n < 3; n++) exp_q.push_back(8'($urandom));
      @(negedge clk);
      foreach (exp_q[n]) send_rx_frame(exp_q[n], 1'b1);
      repeat (8) @(negedge clk);
      checks++; if (rcv_q.size() - s0 != 3) begin
         errors++; $display("FAIL b2b_count: got %0d expected 3", rcv_q.size() - s0); end
      else begin
         foreach (exp_q[n]) begin
            checks++;
            if (rcv_q[s0 + n] !== exp_q[n]) begin
               errors++; $display("FAIL b2b_byte%0d: got %h expected %h", n, rcv_q[s0 + n], exp_q[n]); end
         end
      end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL b2b_no_error: got %0d expected 0", err_cnt - e0); end
      exp_rx_byte = exp_q[2];
   endtask

   task automatic test_frame_error();
      int r0, e0;
      r0 = rcv_cnt; e0 = err_cnt;
      @(negedge clk);
      send_rx_frame(8'h55, 1'b0);
      repeat (BIT) @(negedge clk);
      checks++; if (is_receiving !== 1'b1) begin errors++; $display("FAIL ferr_wait_idle: got %b expected 1", is_receiving); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", err_cnt - e0); end
      checks++; if (rcv_cnt != r0) begin errors++; $display("FAIL ferr_no_received: got %0d expected 0", rcv_cnt - r0); end
      checks++; if (rx_byte !== exp_rx_byte) begin errors++; $display("FAIL ferr_rx_byte: got %h expected %h", rx_byte, exp_rx_byte); end
      rx_drv = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (is_receiving !== 1'b0) begin errors++; $display("FAIL ferr_recover: got %b expected 0", is_receiving); end
   endtask

   task automatic test_glitch();
      int r0, e0;
      r0 = rcv_cnt; e0 = err_cnt;
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (CD) @(negedge clk);
      checks++; if (is_receiving !== 1'b1) begin errors++; $display("FAIL glitch_detect: got %b expected 1", is_receiving); end
      rx_drv = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checks++; if (is_receiving !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", is_receiving); end
      checks++; if (rcv_cnt != r0 || err_cnt != e0) begin
         errors++; $display("FAIL glitch_pulses: got rcv=%0d err=%0d expected 0 0", rcv_cnt - r0, err_cnt - e0); end
   endtask

   task automatic test_loopback(input logic [7:0] b1, input logic [7:0] b2);
      int r1, r2, e1, e2;
      realtime t1, t2, lat1, lat2;
      r1 = rcv2_cnt; r2 = rcv_cnt; e1 = err2_cnt; e2 = err_cnt;
      t1 = 0.0; t2 = 0.0;
      fork
         begin @(negedge clk); tx_byte = b1; transmit = 1'b1; t1 = $realtime; @(negedge clk); transmit = 1'b0; end
         begin @(negedge clk2); tx_byte2 = b2; transmit2 = 1'b1; t2 = $realtime; @(negedge clk2); transmit2 = 1'b0; end
      join
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (rcv2_cnt != r1 && rcv_cnt != r2) break;
      end
      repeat (BIT) @(negedge clk);
      lat1 = rcv2_time - t1;
      lat2 = rcv_time - t2;
      checks++; if (rcv2_cnt - r1 != 1 || rcv2_val !== b1) begin
         errors++; $display("FAIL lb_a2b: got n=%0d byte=%h expected n=1 byte=%h", rcv2_cnt - r1, rcv2_val, b1); end
      checks++; if (rcv_cnt - r2 != 1 || rcv_val !== b2) begin
         errors++; $display("FAIL lb_b2a: got n=%0d byte=%h expected n=1 byte=%h", rcv_cnt - r2, rcv_val, b2); end
      checks++; if (err2_cnt != e1 || err_cnt != e2) begin
         errors++; $display("FAIL lb_errors: got %0d %0d expected 0 0", err2_cnt - e1, err_cnt - e2); end
      checks++; if (lat1 < FRAME * 10 - 20 || lat1 > FRAME * 10 + 70) begin
         errors++; $display("FAIL lb_latency_a2b: got %0t expected about %0d ns", lat1, FRAME * 10); end
      checks++; if (lat2 < FRAME * 10 - 20 || lat2 > FRAME * 10 + 70) begin
         errors++; $display("FAIL lb_latency_b2a: got %0t expected about %0d ns", lat2, FRAME * 10); end
      exp_rx_byte = b2;
   endtask

   task automatic test_reset_midframe();
      logic [9:0] fb;
      int r0, e0;
      fb = frame_bits(8'($urandom), 1'b1);
      @(negedge clk);
      tx_byte = 8'($urandom);
      transmit = 1'b1;
      for (int k = 0; k < 15 * CD; k++) begin
         rx_drv = fb[k / BIT];
         @(negedge clk);
         transmit = 1'b0;
      end
      checks++; if (is_receiving !== 1'b1 || is_transmitting !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got rx=%b tx=%b expected 1 1", is_receiving, is_transmitting); end
      r0 = rcv_cnt; e0 = err_cnt;
      rst = 1'b1;
      rx_drv = 1'b1;
      @(negedge clk);
      checks++; if (tx !== 1'b1 || is_transmitting !== 1'b0 || is_receiving !== 1'b0) begin
         errors++; $display("FAIL rstmid_abort: got tx=%b busy_tx=%b busy_rx=%b expected 1 0 0",
                            tx, is_transmitting, is_receiving); end
      checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx_byte: got %h expected 00", rx_byte); end
      rst = 1'b0;
      exp_rx_byte = 8'h00;
      repeat (FRAME + BIT) @(negedge clk);
      checks++; if (rcv_cnt != r0 || err_cnt != e0) begin
         errors++; $display("FAIL rstmid_pulses: got rcv=%0d err=%0d expected 0 0", rcv_cnt - r0, err_cnt - e0); end
      checks++; if (tx !== 1'b1 || is_transmitting !== 1'b0) begin
         errors++; $display("FAIL rstmid_stay_idle: got tx=%b busy=%b expected 1 0", tx, is_transmitting); end
   endtask

   initial begin
      rst = 1'b1; rx_drv = 1'b1; lb_sel = 1'b0;
      transmit = 1'b0; transmit2 = 1'b0; tx_byte = 8'h00; tx_byte2 = 8'h00;
      test_reset();
      test_tx(8'h3C, 8'hA5);
      for (int n = 0; n < 3; n++) test_tx(8'($urandom), 8'($urandom));
      test_rx(8'hFA);
      for (int n = 0; n < 3; n++) test_rx(8'($urandom));
      test_rx_busy();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      lb_sel = 1'b1;
      repeat (4) @(negedge clk);
      test_loopback(8'hFA, 8'h05);
      for (int n = 0; n < 3; n++) test_loopback(8'($urandom), 8'($urandom));
      lb_sel = 1'b0;
      repeat (4) @(negedge clk);
      test_reset_midframe();
      checks++; if (both_cnt != 0 || both2_cnt != 0) begin
         errors++; $display("FAIL pulse_overlap: got %0d %0d expected 0 0", both_cnt, both2_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
